// File: rtl/fifo_sync_flags_if.sv
// Bus bundle for fifo_sync_flags: write/read request side plus all status outputs.
//
// Handshake: write and read are requests sampled on the rising clock edge.
// A write is taken only when fifo_full is low. A read is taken only when
// fifo_empty is low. Both flags are judged on the state before that edge.
// A request made against the wrong flag is dropped and sets the matching
// sticky error bit. No ready/acknowledge signal comes back, so the requester
// watches the flags to learn whether a request will be taken.
interface fifo_sync_flags_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             write;
    logic [WIDTH-1:0] data_in;
    logic             read;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             fifo_full;
    logic             fifo_empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output write, data_in, read,
        input  data_out, data_valid, fifo_full, fifo_empty,
               almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  write, data_in, read,
        output data_out, data_valid, fifo_full, fifo_empty,
               almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with wrap-bit pointers, occupancy count, almost flags,
// sticky overflow/underflow and a choice of registered or fall-through read.
module fifo_sync_flags #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 256,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    fifo_sync_flags_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] AF_L = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_L = PW'(AE_LEVEL);

    // Storage is never reset; stale contents are unreachable once pointers clear.
    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    occ;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    rd_addr;
    logic             full;
    logic             empty;
    logic             wr_en;
    logic             rd_en;
    logic             ovf_r;
    logic             unf_r;
    logic [WIDTH-1:0] dout;
    logic             dv;

    assign wr_addr = wr_ptr[AW-1:0];
    assign rd_addr = rd_ptr[AW-1:0];

    // Same address with differing wrap bits means one full lap ahead.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_addr == rd_addr);
    assign empty = (wr_ptr == rd_ptr);
    // Modular difference gives 0..DEPTH directly thanks to the extra wrap bit.
    assign occ   = wr_ptr - rd_ptr;

    // Clear wins over any request in the same cycle.
    assign wr_en = bus.write && !full  && !clr;
    assign rd_en = bus.read  && !empty && !clr;

    // Pointer registers: advance on accepted operations, return to zero on reset/clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Memory write port.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= bus.data_in;
    end

    // Sticky error bits: set on a dropped request, cleared only by reset/clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else if (clr) begin
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else begin
            if (bus.write && full)  ovf_r <= 1'b1;
            if (bus.read  && empty) unf_r <= 1'b1;
        end
    end

    generate
        if (FWFT == 0) begin : g_registered
            // Registered read: data appears one cycle after the accepted read, valid pulses once.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout <= '0;
                    dv   <= 1'b0;
                end else if (clr) begin
                    dout <= '0;
                    dv   <= 1'b0;
                end else begin
                    dv <= rd_en;
                    if (rd_en) dout <= mem[rd_addr];
                end
            end
        end else begin : g_fwft
            // Fall-through: head word is shown whenever something is stored; zero otherwise.
            always_comb begin
                dout = '0;
                dv   = !empty;
                if (!empty) dout = mem[rd_addr];
            end
        end
    endgenerate

    assign bus.data_out     = dout;
    assign bus.data_valid   = dv;
    assign bus.fifo_full    = full;
    assign bus.fifo_empty   = empty;
    assign bus.almost_full  = (occ >= AF_L);
    assign bus.almost_empty = (occ <= AE_L);
    assign bus.count        = occ;
    assign bus.overflow     = ovf_r;
    assign bus.underflow    = unf_r;
endmodule

// File: tb/tb_fifo_sync_flags.sv
// Bench for fifo_sync_flags: a registered-read 256-deep instance and a
// fall-through 16-deep instance driven with identical stimulus, each against
// a queue-based reference model.
module tb_fifo_sync_flags;
    localparam int D0 = 256;
    localparam int D1 = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;

    fifo_sync_flags_if #(.WIDTH(8), .DEPTH(D0)) bus0 ();
    fifo_sync_flags_if #(.WIDTH(8), .DEPTH(D1)) bus1 ();

    fifo_sync_flags #(.WIDTH(8), .DEPTH(D0), .FWFT(0)) u_reg (
        .clk(clk), .rst(rst), .clr(clr), .bus(bus0)
    );
    fifo_sync_flags #(.WIDTH(8), .DEPTH(D1), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .clr(clr), .bus(bus1)
    );

    // Clock and reset
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference models: stored words, sticky bits, and expected registered output.
    logic [7:0] m0[$];
    logic [7:0] m1[$];
    logic [7:0] exp_q[$];
    bit         ovf0, unf0, ovf1, unf1;
    bit         vld0;
    logic [7:0] last0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        int s0, s1;
        s0 = m0.size();
        s1 = m1.size();
        chk("r_count",  32'(bus0.count), 32'(s0));
        chk("r_full",   32'(bus0.fifo_full), 32'(s0 == D0));
        chk("r_empty",  32'(bus0.fifo_empty), 32'(s0 == 0));
        chk("r_afull",  32'(bus0.almost_full), 32'(s0 >= D0 - 4));
        chk("r_aempty", 32'(bus0.almost_empty), 32'(s0 <= 4));
        chk("r_ovf",    32'(bus0.overflow), 32'(ovf0));
        chk("r_unf",    32'(bus0.underflow), 32'(unf0));
        chk("r_valid",  32'(bus0.data_valid), 32'(vld0));
        chk("r_dout",   32'(bus0.data_out), 32'(last0));
        chk("f_count",  32'(bus1.count), 32'(s1));
        chk("f_full",   32'(bus1.fifo_full), 32'(s1 == D1));
        chk("f_empty",  32'(bus1.fifo_empty), 32'(s1 == 0));
        chk("f_afull",  32'(bus1.almost_full), 32'(s1 >= D1 - 4));
        chk("f_aempty", 32'(bus1.almost_empty), 32'(s1 <= 4));
        chk("f_ovf",    32'(bus1.overflow), 32'(ovf1));
        chk("f_unf",    32'(bus1.underflow), 32'(unf1));
        chk("f_valid",  32'(bus1.data_valid), 32'(s1 > 0));
        chk("f_dout",   32'(bus1.data_out), (s1 > 0) ? 32'(m1[0]) : 32'h0);
    endtask

    task automatic model_clear();
        m0.delete();
        m1.delete();
        ovf0 = 0; unf0 = 0; ovf1 = 0; unf1 = 0;
        vld0 = 0; last0 = 8'h00;
    endtask

    // Driver: check the state left by the previous edge, then present one cycle of stimulus.
    task automatic step(input bit w, input logic [7:0] d, input bit r, input bit c);
        bit aw, ar;
        @(negedge clk);
        check_all();
        bus0.write = w; bus0.data_in = d; bus0.read = r;
        bus1.write = w; bus1.data_in = d; bus1.read = r;
        clr = c;
        if (c) begin
            model_clear();
        end else begin
            aw = w && (m0.size() < D0);
            ar = r && (m0.size() > 0);
            vld0 = ar;
            if (w && !aw) ovf0 = 1;
            if (r && !ar) unf0 = 1;
            if (ar) begin
                last0 = m0.pop_front();
                exp_q.push_back(last0);
            end
            if (aw) m0.push_back(d);
            aw = w && (m1.size() < D1);
            ar = r && (m1.size() > 0);
            if (w && !aw) ovf1 = 1;
            if (r && !ar) unf1 = 1;
            if (ar) void'(m1.pop_front());
            if (aw) m1.push_back(d);
        end
    endtask

    // Scoreboard monitor: every registered-read valid pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && bus0.data_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_unexpected act=%0h exp=none t=%0t", bus0.data_out, $time);
            end else begin
                chk("rd_data", 32'(bus0.data_out), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int wp, rp;
        bus0.write = 0; bus0.data_in = 0; bus0.read = 0;
        bus1.write = 0; bus1.data_in = 0; bus1.read = 0;
        model_clear();

        // Reset state, sampled while reset is held.
        @(negedge clk);
        check_all();
        rst = 1'b0;

        // Fill to full, then one rejected write.
        for (int i = 0; i < D0; i++) step(1, 8'(i), 0, 0);
        step(1, 8'hEE, 0, 0);

        // Drain in order, then one rejected read; output must hold the last word.
        for (int i = 0; i < D0; i++) step(0, 8'h00, 1, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0);

        // Clear, then hold occupancy at 10 with simultaneous read+write.
        step(0, 8'h00, 0, 1);
        for (int i = 0; i < 10; i++) step(1, 8'($urandom_range(0, 255)), 0, 0);
        for (int i = 0; i < 20; i++) step(1, 8'($urandom_range(0, 255)), 1, 0);
        for (int i = 0; i < 12; i++) step(0, 8'h00, 1, 0);

        // Long interleaved traffic, occupancy kept at or below 200, pointers wrap.
        for (int i = 0; i < 1200; i++) begin
            if (i < 400)      begin wp = 70; rp = 35; end
            else if (i < 800) begin wp = 35; rp = 70; end
            else              begin wp = 50; rp = 50; end
            step(($urandom_range(0, 99) < wp) && (m0.size() < 200),
                 8'($urandom_range(0, 255)),
                 $urandom_range(0, 99) < rp, 0);
        end
        for (int i = 0; i < 210; i++) step(0, 8'h00, 1, 0);

        // Fall-through: one word into an empty FIFO, then read it back out.
        step(0, 8'h00, 0, 1);
        step(1, 8'hA5, 0, 0);
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0);

        // Asynchronous reset between edges with 37 entries stored.
        for (int i = 0; i < 37; i++) step(1, 8'(i + 100), 0, 0);
        @(negedge clk);
        bus0.write = 0; bus0.read = 0; bus1.write = 0; bus1.read = 0;
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Clear with write high drops the write; next write lands at address 0.
        step(1, 8'h77, 0, 0);
        step(1, 8'h55, 0, 1);
        step(1, 8'h3C, 0, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover act=%0d exp=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
